// File: rtl/ffa2_post_combiner.sv
// ffa2_post_combiner: recombines 2-parallel FFA sub-filter outputs into saturated even/odd lanes with sticky overflow stats
module ffa2_post_combiner #(
    parameter int DW    = 24,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] h0_in,
    input  logic signed [DW-1:0] h01_in,
    input  logic signed [DW-1:0] h1_in,
    input  logic                 clr_stats,
    output logic signed [DW-1:0] y_even,
    output logic signed [DW-1:0] y_odd,
    output logic                 out_valid,
    output logic                 sat_flag,
    output logic [CNT_W-1:0]     sat_count
);
    localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};

    function automatic logic signed [DW+1:0] sx(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    logic signed [DW-1:0] h0_r, h01_r, h1_r, h1_prev, e_cl, o_cl;
    logic signed [DW+1:0] e_full, o_full;
    logic                 s1_valid, e_sat, o_sat, sat_event;

    // combine lanes in DW+2 bits so no intermediate can wrap, then clamp
    always_comb begin
        e_full    = sx(h0_r) + sx(h1_prev);
        o_full    = sx(h01_r) - sx(h0_r) - sx(h1_r);
        e_sat     = (e_full > MAXV) || (e_full < MINV);
        o_sat     = (o_full > MAXV) || (o_full < MINV);
        e_cl      = e_full > MAXV ? MAXV[DW-1:0] : e_full < MINV ? MINV[DW-1:0] : e_full[DW-1:0];
        o_cl      = o_full > MAXV ? MAXV[DW-1:0] : o_full < MINV ? MINV[DW-1:0] : o_full[DW-1:0];
        sat_event = e_sat || o_sat;
    end

    // capture accepted blocks; h1_prev only advances on accepts so bubbles keep the z^-1 alignment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h0_r     <= '0;
            h01_r    <= '0;
            h1_r     <= '0;
            h1_prev  <= '0;
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                h0_r    <= h0_in;
                h01_r   <= h01_in;
                h1_r    <= h1_in;
                h1_prev <= h1_r;
            end
        end
    end

    // output registers load on every enabled cycle; out_valid qualifies them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_even    <= '0;
            y_odd     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            y_even    <= e_cl;
            y_odd     <= o_cl;
            out_valid <= s1_valid;
        end
    end

    // sticky saturation statistics; clear ignores en and beats a coincident event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (clr_stats) begin
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (en && s1_valid && sat_event) begin
            sat_flag <= 1'b1;
            if (!(&sat_count)) sat_count <= sat_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ffa2_post_combiner.sv
// tb_ffa2_post_combiner: directed checks of combining, z^-1 alignment, bubbles, stalls, saturation and stats
module tb_ffa2_post_combiner;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b0;
    logic               in_valid = 1'b0;
    logic               clr_stats = 1'b0;
    logic signed [23:0] h0_in = '0, h01_in = '0, h1_in = '0;
    logic signed [23:0] y_even, y_odd;
    logic               out_valid, sat_flag;
    logic [3:0]         sat_count;
    int                 tests = 0;
    int                 fails = 0;

    ffa2_post_combiner #(.DW(24), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .h0_in(h0_in), .h01_in(h01_in), .h1_in(h1_in), .clr_stats(clr_stats),
        .y_even(y_even), .y_odd(y_odd), .out_valid(out_valid),
        .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // apply inputs at a negedge, then wait to the next negedge so one posedge has taken them
    task automatic step(input logic e, input logic v, input int a, input int b, input int c, input logic clr);
        en = e;
        in_valid = v;
        h0_in = 24'(a);
        h01_in = 24'(b);
        h1_in = 24'(c);
        clr_stats = clr;
        @(negedge clk);
    endtask

    task automatic out(input string tag, input logic v, input int ye, input int yo);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_even"}, $signed(y_even), 64'(ye));
        check({tag, "_odd"}, $signed(y_odd), 64'(yo));
    endtask

    task automatic stats(input string tag, input logic f, input int n);
        check({tag, "_flag"}, 64'(sat_flag), 64'(f));
        check({tag, "_count"}, 64'(sat_count), 64'(n));
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1;
        out("rst0", 1'b0, 0, 0);
        stats("rst0", 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;

        // saturation: first block exact, second clamps both lanes
        step(1, 1, 8388607, 0, 1, 0);
        step(1, 1, 8388607, -8388608, 8388607, 0);
        out("sat1", 1'b1, 8388607, -8388608);
        stats("sat1", 1'b0, 0);
        step(1, 0, 0, 0, 0, 0);
        out("sat2", 1'b1, 8388607, -8388608);
        stats("sat2", 1'b1, 1);
        step(1, 0, 0, 0, 0, 0);
        check("sat_idle_valid", 64'(out_valid), 64'(0));
        stats("sat_idle", 1'b1, 1);

        // asynchronous reset mid-cycle clears everything without a clock edge
        en = 1'b1; in_valid = 1'b1; h0_in = 24'd77; h01_in = 24'd88; h1_in = 24'd99;
        #2 reset = 1'b0;
        #1;
        out("rst_mid", 1'b0, 0, 0);
        stats("rst_mid", 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;

        // continuous two-block stream
        step(1, 1, 100, 300, 50, 0);
        check("strA_pre_valid", 64'(out_valid), 64'(0));
        step(1, 1, 10, 30, 5, 0);
        out("strA", 1'b1, 100, 150);
        step(1, 0, 0, 0, 0, 0);
        out("strB", 1'b1, 60, 15);
        step(1, 0, 0, 0, 0, 0);
        check("str_end_valid", 64'(out_valid), 64'(0));

        // bubble between blocks leaves the delay line untouched
        do_reset();
        step(1, 1, 100, 300, 50, 0);
        step(1, 0, 999, 999, 999, 0);
        out("bubA", 1'b1, 100, 150);
        step(1, 1, 10, 30, 5, 0);
        check("bub_gap_valid", 64'(out_valid), 64'(0));
        step(1, 0, 0, 0, 0, 0);
        out("bubB", 1'b1, 60, 15);

        // stall: en low holds outputs and ignores presented inputs
        do_reset();
        step(1, 1, 100, 300, 50, 0);
        step(1, 1, 10, 30, 5, 0);
        out("stlA", 1'b1, 100, 150);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1234, 4321, 777, 0);
            out("stl_hold", 1'b1, 100, 150);
        end
        step(1, 0, 0, 0, 0, 0);
        out("stlB", 1'b1, 60, 15);

        // clear coincident with a saturation event wins
        do_reset();
        step(1, 1, 8388607, 0, 1, 0);
        step(1, 1, 8388607, -8388608, 8388607, 0);
        step(1, 1, 8388607, -8388608, 8388607, 0);
        stats("clr_pre", 1'b1, 1);
        step(1, 0, 0, 0, 0, 1);
        out("clr_out", 1'b1, 8388607, -8388608);
        stats("clr_same", 1'b0, 0);

        // counter ceiling with 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8388607, -8388608, 8388607, 0);
            if (i == 15) stats("ceil_mid", 1'b1, 15);
        end
        step(1, 0, 0, 0, 0, 0);
        stats("ceil", 1'b1, 15);

        // clear acts even while en is low
        step(0, 0, 0, 0, 0, 1);
        stats("clr_en0", 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ffa2_post_combiner.md
# ffa2_post_combiner

Output recombination stage for the 2-parallel fast-FIR (FFA) filter. It sits directly downstream of the three half-length broadcast sub-filters: H0 on even samples, (H0+H1) on summed samples, and H1 on odd samples. It combines their 24-bit outputs into the even and odd lanes of the full-rate filter response. It applies the block-domain z^-1 delay, saturates both lanes, and keeps sticky overflow statistics.

## Interface
Parameters:
- DW, 24, width of sub-filter outputs and of both output lanes (signed)
- CNT_W, 16, width of saturation event counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  global advance, same enable that drives the sub-filters; when low, all state holds
- in_valid  input  1  sub-filter outputs present a valid block this cycle
- h0_in  input  DW  H0 sub-filter output, signed
- h01_in  input  DW  (H0+H1) sub-filter output, signed
- h1_in  input  DW  H1 sub-filter output, signed
- clr_stats  input  1  synchronous clear of sat_flag and sat_count
- y_even  output  DW  even-lane output y(2k), signed
- y_odd  output  DW  odd-lane output y(2k+1), signed
- out_valid  output  1  y_even/y_odd hold a new valid block
- sat_flag  output  1  sticky: at least one lane clamped since last clear
- sat_count  output  CNT_W  number of valid output blocks with at least one lane clamped; saturates at all-ones

## Operation
- Accept condition: en=1 and in_valid=1.
- Stage 1 (S1), on accept:
  - register h0_r<=h0_in, h01_r<=h01_in, h1_r<=h1_in
  - h1_prev<=h1_r, which is the H1 value of the previously accepted block
  - s1_valid<=1
- On en=1 and in_valid=0: s1_valid<=0. h0_r, h01_r, h1_r and h1_prev hold, so bubbles do not advance the z^-1 delay.
- Stage 2 (S2), on en=1:
  - e_full = h0_r + h1_prev, sign-extended to DW+2 bits
  - o_full = h01_r − h0_r − h1_r, sign-extended to DW+2 bits
  - each lane is clamped to [−2^(DW−1), 2^(DW−1)−1] and then registered into y_even/y_odd
  - out_valid<=s1_valid
- S2 registers load every en=1 cycle, even when s1_valid=0. Outputs are only meaningful while out_valid=1.
- h1_prev reset value is 0, so the first output block uses y_even = h0.
- Statistics are evaluated on en=1 cycles where s1_valid=1:
  - sat_event = e clamped OR o clamped
  - sat_event sets sat_flag
  - sat_event increments sat_count unless it is all-ones
- clr_stats=1 clears sat_flag and sat_count to 0. Clear wins over a simultaneous sat_event, so that event is not counted.
- en=0: every register holds, including out_valid and statistics. clr_stats still acts regardless of en.

## Timing
- Reset (reset=0, asynchronous): every output is 0 immediately, and all internal registers (h0_r, h01_r, h1_r, h1_prev, s1_valid) are 0. Deassertion is synchronised by the integrator upstream.
- Latency: a block accepted at edge N appears on y_even/y_odd with out_valid=1 after edge N+1, provided en=1 at N+1. Latency is 2 en-cycles.
- Throughput: one block (two output samples) per en-cycle.
- out_valid is high for exactly one en-cycle per accepted block. Consecutive accepts give a continuous out_valid.
- Reset mid-stream: in-flight blocks are discarded and h1_prev returns to 0. The first block after reset behaves as the first block of a stream.
- No back-pressure: the consumer must accept every out_valid cycle.

## Test plan
- Reset: drive nonzero inputs, then reset=0 mid-cycle -> y_even=y_odd=0, out_valid=0, sat_flag=0, sat_count=0 immediately, without waiting for a clock edge.
- Two-block stream: block A (h0=100, h01=300, h1=50), then block B (10, 30, 5), en=1 continuous -> block A outputs y_even=100, y_odd=150; block B outputs y_even=60, y_odd=15. Each appears 2 cycles after its accept.
- Bubble: block A, then one cycle with in_valid=0, then block B -> out_valid pattern 1,0,1. B still gives y_even=60, showing h1_prev was unchanged by the bubble.
- Stall: en=0 for 3 cycles between A and B -> outputs, out_valid and h1_prev hold. Results equal those of the continuous case.
- Saturation:
  - block (h0=8388607, h01=0, h1=1), then block (h0=8388607, h01=−8388608, h1=8388607) -> second output has y_even=8388607 (clamped) and y_odd=−8388608 (clamped)
  - after these, sat_flag=1 and sat_count=1; the first block's y_odd=−8388608 is exact, not clamped
  - clr_stats=1 in the same cycle as a further sat_event -> sat_count=0, sat_flag=0
- Counter ceiling: CNT_W=4, 20 consecutive saturating blocks -> sat_count stops at 15, sat_flag=1.
